// File: rtl/scarv_ccx_pkg.sv
// Shared types for the core-complex MMIO arbiter: arbitration states and requester count.
package scarv_ccx_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } arb_state_e;

    localparam int NUM_RQ = 2;

endpackage

// File: rtl/scarv_ccx_rr_pick.sv
// Two-way round-robin pick: on a tie the requester that did not win last time is chosen.
module scarv_ccx_rr_pick
    import scarv_ccx_pkg::*;
(
    input  logic [NUM_RQ-1:0] req,
    input  logic              last,
    output logic              sel,
    output logic              any
);

    assign any = |req;
    assign sel = (&req) ? ~last : req[1];

endmodule

// File: rtl/scarv_ccx_mmio_arb.sv
// Shares the MMIO responder between the core data port (rq0) and the debug/DMA port (rq1);
// a stalled request is locked until granted, responses route back with no added latency.
module scarv_ccx_mmio_arb
    import scarv_ccx_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              f_clk,
    input  logic              g_resetn,

    input  logic              rq0_req,
    output logic              rq0_gnt,
    input  logic              rq0_wen,
    input  logic [3:0]        rq0_strb,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic [DATA_W-1:0] rq0_rdata,
    output logic              rq0_error,

    input  logic              rq1_req,
    output logic              rq1_gnt,
    input  logic              rq1_wen,
    input  logic [3:0]        rq1_strb,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic [DATA_W-1:0] rq1_rdata,
    output logic              rq1_error,

    output logic              dn_req,
    input  logic              dn_gnt,
    output logic              dn_wen,
    output logic [3:0]        dn_strb,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [DATA_W-1:0] dn_wdata,
    input  logic [DATA_W-1:0] dn_rdata,
    input  logic              dn_error,

    output logic              owner
);

    arb_state_e arb_q, arb_d;
    logic       last_q, last_d;
    logic       rsp_v_q;
    logic       rsp_id_q;

    logic       pick_sel, pick_any;
    logic       sel, active, accept;

    scarv_ccx_rr_pick u_pick (
        .req  ({rq1_req, rq0_req}),
        .last (last_q),
        .sel  (pick_sel),
        .any  (pick_any)
    );

    // Reset gates the request path directly so an asynchronous reset silences dn and all grants at once.
    always_comb begin
        arb_d  = arb_q;
        last_d = last_q;
        sel    = pick_sel;
        active = 1'b0;
        case (arb_q)
            ARB: begin
                active = pick_any;
                if (pick_any) begin
                    if (dn_gnt) last_d = pick_sel;
                    else        arb_d  = pick_sel ? HOLD1 : HOLD0;
                end
            end
            HOLD0: begin
                sel    = 1'b0;
                active = rq0_req;
                if (!rq0_req) begin
                    arb_d = ARB;
                end else if (dn_gnt) begin
                    last_d = 1'b0;
                    arb_d  = ARB;
                end
            end
            HOLD1: begin
                sel    = 1'b1;
                active = rq1_req;
                if (!rq1_req) begin
                    arb_d = ARB;
                end else if (dn_gnt) begin
                    last_d = 1'b1;
                    arb_d  = ARB;
                end
            end
            default: arb_d = ARB;
        endcase
        active = active & g_resetn;
    end

    assign owner    = active & sel;
    assign accept   = active & dn_gnt;
    assign rq0_gnt  = accept & ~sel;
    assign rq1_gnt  = accept &  sel;

    assign dn_req   = active;
    assign dn_wen   = active & (sel ? rq1_wen : rq0_wen);
    assign dn_strb  = active ? (sel ? rq1_strb  : rq0_strb)  : '0;
    assign dn_addr  = active ? (sel ? rq1_addr  : rq0_addr)  : '0;
    assign dn_wdata = active ? (sel ? rq1_wdata : rq0_wdata) : '0;

    always_ff @(posedge f_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            arb_q    <= ARB;
            last_q   <= 1'b1;
            rsp_v_q  <= 1'b0;
            rsp_id_q <= 1'b0;
        end else begin
            arb_q   <= arb_d;
            last_q  <= last_d;
            rsp_v_q <= accept;
            if (accept) rsp_id_q <= owner;
        end
    end

    // Response is steered by who was accepted last cycle, then passed straight through.
    logic rsp0, rsp1;
    assign rsp0      = g_resetn & rsp_v_q & ~rsp_id_q;
    assign rsp1      = g_resetn & rsp_v_q &  rsp_id_q;
    assign rq0_rdata = rsp0 ? dn_rdata : '0;
    assign rq0_error = rsp0 & dn_error;
    assign rq1_rdata = rsp1 ? dn_rdata : '0;
    assign rq1_error = rsp1 & dn_error;

endmodule

// File: doc/scarv_ccx_mmio_arb.md
# scarv_ccx_mmio_arb

Two-requester arbiter sharing the core complex MMIO responder (mtime/mtimecmp/TRNG register block) between the core data port and a second master (debug/DMA port). It sits between the requesters and the single MMIO responder memif. It applies round-robin arbitration and locks a request that the responder has not yet granted. It routes the single-cycle-latency responses back to the owning requester with no added latency.

## Interface

Parameters:
- `ADDR_W`, 32: address width carried through unchanged.
- `DATA_W`, 32: `wdata`/`rdata` width.

Ports:
- `f_clk` in 1: global clock.
- `g_resetn` in 1: reset, asynchronous, active-low.
- `rq0` memif RSP, bundle: requester 0 (core data port). Carries `req`, `gnt`, `wen`, `strb[3:0]`, `addr`, `wdata`, `rdata`, `error`.
- `rq1` memif RSP, bundle: requester 1 (debug/DMA port), same signals.
- `dn` memif REQ, bundle: downstream MMIO responder.
- `owner` out 1: index of the requester currently driven onto `dn` (visibility and assertions only).

## Operation

Memif rules:
- A requester holds `req`, `addr`, `wen`, `strb` and `wdata` stable until it sees `req && gnt`.
- The responder drives `rdata` and `error` in the cycle after acceptance.

State machine `arb_q`:
- `ARB`: select a requester combinationally.
  - Only one `req` high: that requester is selected.
  - Both high: the requester not equal to `last_q` is selected.
  - Selection drives `dn.req/addr/wen/strb/wdata` and `owner`.
  - `dn.gnt` high: the selected requester's `gnt` goes high the same cycle, `last_q` is updated to the selected index, and the state stays `ARB`.
  - `dn.gnt` low: go to `HOLD0` or `HOLD1` for the selected index.
- `HOLDn`: requester n stays selected regardless of the other `req`.
  - `dn.gnt` high: `rqn.gnt` goes high, `last_q` is set to n, go to `ARB`.
  - `rqn.req` drops while held: this is a protocol violation. Return to `ARB` and grant nothing.
- The non-selected requester's `gnt` is always 0.
- No `req` high: `dn.req` is 0 and `dn` data outputs are 0.

Response routing:
- `rsp_v_q` is set to (`dn.req && dn.gnt`) each cycle.
- `rsp_id_q` captures `owner` at acceptance.
- `rqN.rdata` and `rqN.error` equal `dn.rdata` and `dn.error` when `rsp_v_q && rsp_id_q==N`, and are 0 otherwise. This path is combinational.
- Back-to-back acceptances are allowed. A response for transaction k and the grant for k+1 can coincide in the same cycle.

Reset:
- `arb_q` = `ARB`, `last_q` = 1 so requester 0 wins the first tie, `rsp_v_q` = 0, `rsp_id_q` = 0.
- As a result all `gnt`, `rdata`, `error` and `dn.req` outputs are 0 and `owner` = 0.
- Reset asserted mid-hold or mid-response aborts it; the pending response is not delivered.

## Timing

- Grant latency: 0 cycles when `dn.gnt` is already high.
- Response: exactly 1 cycle after `req && gnt`, passed straight through from `dn`.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1.
- Under a permanent `dn.gnt` = 1, each requester waits at most one transaction.
- In `HOLD`, a newly raised request from the other requester has no effect until return to `ARB`.
- Simultaneous arrivals in `ARB`: the requester that did not win last time wins, determined by `last_q` alone.

## Structure

- Package `scarv_ccx_pkg` holds the arbitration state enum (`ARB`, `HOLD0`, `HOLD1`) and `localparam NUM_RQ = 2`.
- One optional sub-module, `scarv_ccx_rr_pick`: a 2-way round-robin pick from `req[1:0]` and `last`, giving `sel` and `any`.
- Everything else stays flat in this module.

## Test plan

- Solo traffic: requester 0 reads 0x1000 with `dn.gnt` = 1.
  - `rq0.gnt` is high in the same cycle.
  - Next cycle `rq0.rdata` equals the mtime low word and `rq1.rdata` = 0.
- Simultaneous requests after reset: both read, 0x1000 and 0x1008.
  - Requester 0 is granted first and requester 1 in the next cycle.
  - Each receives its own data and `rsp_id_q` is correct each cycle.
- Stall lock: `dn.gnt` held low for 3 cycles while requester 1 is selected, and requester 0 raises `req` during the stall.
  - `owner` stays 1 and `rq1.gnt` rises on the 4th cycle.
  - Requester 0 is then granted.
- Error routing: requester 1 reads 0x10FC, an unmapped address.
  - Next cycle `rq1.error` = 1 and `rq0.error` = 0.
- Back-to-back writes: requester 0 writes mtimecmp low = 0x10 and requester 1 writes mtimecmp high = 0x0 on alternating cycles over 8 transactions.
  - Grants alternate with no bubbles and none is lost.
- Async reset: reset asserted in `HOLD0` between clock edges.
  - All `gnt`, `rdata` and `error` outputs and `dn.req` drop immediately.
  - After release, requester 0 wins the first tie.
